fwd_hazard_unit: RTL

Parametrised operand-forwarding and load-use hazard unit for the ID/EX boundary of the 5-stage RV32I core. Tracks the destination registers of the last FWD_DEPTH issued instructions in an internal scoreboard shift register. Selects the youngest matching result for rs1/rs2, applies the pc/imm operand muxing, and asserts a stall when a load result is not yet available.

---
 rtl/fwd_hazard_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection at the ID/EX boundary.
// Define FWD_STATS_EN to add saturating stall/forward event counters.
module fwd_hazard_unit #(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid_i,
  input  logic [31:0]               instr_i,
  input  logic [XLEN-1:0]           pc_i,
  input  logic [XLEN-1:0]           imm_i,
  input  logic [XLEN-1:0]           r1_data_i,
  input  logic [XLEN-1:0]           r2_data_i,
  input  logic [FWD_DEPTH*XLEN-1:0] fwd_data_i,
  input  logic                      flush_i,
  output logic [XLEN-1:0]           op1_o,
  output logic [XLEN-1:0]           op2_o,
  output logic [XLEN-1:0]           data_o,
  output logic [4:0]                rs1_o,
  output logic [4:0]                rs2_o,
  output logic                      stall_o
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               fwd_cnt_o
`endif
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

  sb_entry_t sb_q [FWD_DEPTH];
  sb_entry_t sb_new;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic       is_r, is_i, is_l, is_s, is_b, is_lui, is_auipc, is_jal, is_jalr;
  logic       writes_rd, use_rs1, use_rs2, issue;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic       rs1_hit, rs2_hit, ld_hz;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign rd          = instr_i[11:7];
  assign rs1_o       = instr_i[19:15];
  assign rs2_o       = instr_i[24:20];
  assign unused_bits = ^{instr_i[31:25], instr_i[14:12]};

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_l     = (opcode == OP_L);
  assign is_s     = (opcode == OP_S);
  assign is_b     = (opcode == OP_B);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);

  assign writes_rd = is_r | is_i | is_l | is_lui | is_auipc | is_jal | is_jalr;
  assign use_rs1   = ~(is_lui | is_auipc | is_jal);
  assign use_rs2   = is_r | is_s | is_b;

  // Walk oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    rs1_val = r1_data_i;
    rs2_val = r2_data_i;
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    ld_hz   = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (use_rs1 && rs1_o != 5'd0 && sb_q[k].v && sb_q[k].rd == rs1_o) begin
        rs1_val = fwd_data_i[k*XLEN +: XLEN];
        rs1_hit = 1'b1;
        if (k < LOAD_LAT && sb_q[k].ld) ld_hz = 1'b1;
      end
      if (use_rs2 && rs2_o != 5'd0 && sb_q[k].v && sb_q[k].rd == rs2_o) begin
        rs2_val = fwd_data_i[k*XLEN +: XLEN];
        rs2_hit = 1'b1;
        if (k < LOAD_LAT && sb_q[k].ld) ld_hz = 1'b1;
      end
    end
  end

  assign stall_o = id_valid_i && !flush_i && ld_hz;
  assign issue   = id_valid_i && !stall_o && !flush_i;

  always_comb begin
    sb_new    = '0;
    sb_new.v  = issue && writes_rd && (rd != 5'd0);
    sb_new.rd = sb_new.v ? rd : 5'd0;
    sb_new.ld = sb_new.v && is_l;
  end

  // A stalled or flushed slot shifts in as a bubble so older loads keep draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < FWD_DEPTH; k++) sb_q[k] <= '0;
    end else begin
      sb_q[0] <= sb_new;
      for (int k = 1; k < FWD_DEPTH; k++) sb_q[k] <= sb_q[k-1];
    end
  end

  assign op1_o  = (is_b | is_auipc | is_jal | is_jalr) ? pc_i : rs1_val;
  assign op2_o  = (is_s | is_i | is_b | is_jal | is_jalr | is_lui | is_auipc | is_l)
                  ? imm_i : rs2_val;
  assign data_o = rs2_val;

`ifdef FWD_STATS_EN
  logic fwd_event;

  assign fwd_event = id_valid_i && !flush_i && !stall_o && (rs1_hit || rs2_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (fwd_event && fwd_cnt_o != 32'hFFFF_FFFF) fwd_cnt_o <= fwd_cnt_o + 32'd1;
    end
  end
`endif

endmodule
